// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and
// holds the fetched word in the IF/ID register toward decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc4_q, if_pc4_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        load_ok;
  logic        pc_legal;

  // Handshake: decode takes the IF/ID contents on an edge with if_valid=1 and
  // id_ready=1; while if_valid=1 and id_ready=0 the contents are held, and only
  // a redirect may drop them.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_pc4_d   = if_pc4_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;

    load_ok  = (state_q == ST_RUN) && !redirect_valid && (!if_valid_q || id_ready);
    pc_legal = (pc_q <= LAST_PC) && (pc_q[1:0] == 2'b00);

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          // Redirect wins over any load; the held word is flushed either way.
          if_valid_d = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            state_d    = ST_HALT;
            fault_d    = 1'b1;
            fault_pc_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (load_ok) begin
          if (pc_legal) begin
            if_instr_d = mem_instruction;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + 32'd4;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else begin
            state_d    = ST_HALT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            if_valid_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= 32'd0;
      if_pc_q    <= 32'd0;
      if_pc4_q   <= 32'd0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_pc4_q   <= if_pc4_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign mem_address    = pc_q;
  assign if_valid       = if_valid_q;
  assign if_instruction = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc4_q;
  assign fault          = fault_q;
  assign fault_pc       = fault_pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed plan steps plus random traffic checked
// against a behavioural fetch model and an in-order delivery scoreboard.
module tb_instruction_fetch;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // main DUT (256-byte memory)
  logic [31:0] mem_address, mem_instruction;
  logic        redirect_valid, id_ready;
  logic [31:0] redirect_target;
  logic        if_valid, fault;
  logic [31:0] if_instruction, if_pc, if_pc_plus4, fault_pc;
  logic [1:0]  dbg_state;

  // small DUT (16-byte memory) for the out-of-range case
  logic [31:0] s_mem_address, s_mem_instruction;
  logic        s_redirect_valid, s_id_ready;
  logic [31:0] s_redirect_target;
  logic        s_if_valid, s_fault;
  logic [31:0] s_if_instruction, s_if_pc, s_if_pc_plus4, s_fault_pc;
  logic [1:0]  s_dbg_state;

  logic [31:0] mem [0:63];
  assign mem_instruction   = mem[mem_address[7:2]];
  assign s_mem_instruction = mem[s_mem_address[7:2]];

  instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
    .clk(clk), .reset(reset), .mem_address(mem_address),
    .mem_instruction(mem_instruction), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .id_ready(id_ready),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .fault(fault), .fault_pc(fault_pc),
    .dbg_state(dbg_state)
  );

  instruction_fetch #(.RESET_PC(32'h0), .MEM_BYTES(16)) dut_s (
    .clk(clk), .reset(reset), .mem_address(s_mem_address),
    .mem_instruction(s_mem_instruction), .redirect_valid(s_redirect_valid),
    .redirect_target(s_redirect_target), .id_ready(s_id_ready),
    .if_valid(s_if_valid), .if_instruction(s_if_instruction), .if_pc(s_if_pc),
    .if_pc_plus4(s_if_pc_plus4), .fault(s_fault), .fault_pc(s_fault_pc),
    .dbg_state(s_dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // behavioural model of the fetch stage
  logic        m_booted, m_halted, m_valid, m_fault;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_fpc;
  logic [31:0] exp_q[$];  // next address decode must receive, in program order

  task automatic m_reset();
    m_booted = 1'b0; m_halted = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_fpc = 32'h0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic m_tick();
    logic [31:0] nxt;
    if (m_valid && id_ready) begin
      nxt = exp_q.pop_front();
      chk("sb_order", if_pc, nxt);
      exp_q.push_back(nxt + 32'd4);
    end
    if (m_halted) begin
    end else if (!m_booted) begin
      m_booted = 1'b1;
    end else if (redirect_valid) begin
      m_valid = 1'b0;
      if (redirect_target % 4 != 0) begin
        m_halted = 1'b1; m_fault = 1'b1; m_fpc = redirect_target;
      end else begin
        m_pc = redirect_target;
        exp_q.delete();
        exp_q.push_back(redirect_target);
      end
    end else if (!m_valid || id_ready) begin
      if (m_pc < 32'd256 && m_pc % 4 == 0) begin
        m_instr = mem[m_pc / 4];
        m_ipc   = m_pc;
        m_ipc4  = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else begin
        m_halted = 1'b1; m_fault = 1'b1; m_fpc = m_pc; m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_pc", if_pc, m_ipc);
    chk("if_instruction", if_instruction, m_instr);
    chk("if_pc_plus4", if_pc_plus4, m_ipc4);
    chk("mem_address", mem_address, m_pc);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fpc);
  endtask

  // driver: one clock edge, model advanced with the inputs seen at that edge
  task automatic step();
    m_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // async reset asserted between edges, released one cycle later
  task automatic do_reset();
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0080_0513;
    mem[1] = 32'h0095_0593;
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'h0; id_ready = 1'b1;
    s_redirect_valid = 1'b0; s_redirect_target = 32'h0; s_id_ready = 1'b1;
    m_reset();

    // reset values
    #12;
    check_all();
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // boot: E1 no fetch, E2 word 0, E3 word 1
    step();
    chk("boot_e1_valid", 32'(if_valid), 32'h0);
    step();
    chk("boot_e2_instr", if_instruction, 32'h0080_0513);
    chk("boot_e2_pc", if_pc, 32'h0);
    chk("boot_e2_pc4", if_pc_plus4, 32'h4);
    step();
    chk("boot_e3_instr", if_instruction, 32'h0095_0593);
    chk("boot_e3_pc", if_pc, 32'h4);
    step();
    chk("bp_start_pc", if_pc, 32'h8);

    // backpressure for three cycles at if_pc=8
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_pc", if_pc, 32'h8);
      chk("bp_hold_instr", if_instruction, mem[2]);
      chk("bp_hold_addr", mem_address, 32'hc);
    end
    id_ready = 1'b1;
    step();
    chk("bp_release_pc", if_pc, 32'hc);

    // redirect to 0x10 with id_ready low
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h10;
    step();
    chk("redir_flush", 32'(if_valid), 32'h0);
    redirect_valid = 1'b0;
    step();
    chk("redir_pc", if_pc, 32'h10);
    chk("redir_instr", if_instruction, mem[4]);
    chk("redir_valid", 32'(if_valid), 32'h1);

    // misaligned redirect, then stay frozen under random inputs
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h6;
    step();
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_fault_pc", fault_pc, 32'h6);
    chk("mis_valid", 32'(if_valid), 32'h0);
    for (int i = 0; i < 10; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_target = 32'($urandom_range(0, 63)) << 2;
      step();
      chk("halt_frozen_addr", mem_address, 32'h14);
      chk("halt_fault_pc", fault_pc, 32'h6);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;

    // reset during HALT, then normal boot
    do_reset();
    step();
    step();
    chk("reboot_pc", if_pc, 32'h0);
    chk("reboot_valid", 32'(if_valid), 32'h1);

    // reset during backpressure
    id_ready = 1'b0;
    step();
    step();
    do_reset();
    id_ready = 1'b1;

    // out of range on the 16-byte instance
    for (int i = 0; i < 5; i++) begin
      step();
      if (i >= 1) begin
        chk("oor_pc", s_if_pc, 32'(4 * (i - 1)));
        chk("oor_instr", s_if_instruction, mem[i - 1]);
        chk("oor_valid", 32'(s_if_valid), 32'h1);
      end
    end
    step();
    chk("oor_fault", 32'(s_fault), 32'h1);
    chk("oor_fault_pc", s_fault_pc, 32'h10);
    chk("oor_valid_drop", 32'(s_if_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("oor_frozen_addr", s_mem_address, 32'h10);
      chk("oor_fault_hold", 32'(s_fault), 32'h1);
    end

    // random traffic with periodic resets
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 100; i++) begin
        id_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 15) == 0);
        t = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 39) == 0) t = t | 32'h2;
        redirect_target = t;
        step();
      end
      redirect_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the rv32 core. It owns the program counter and drives a byte address to the combinational instruction memory. It registers the returned 32-bit word, with its PC, into the IF/ID register using a valid/ready handshake toward decode. It accepts branch/jump redirects from later stages and halts with a sticky fault on a misaligned or out-of-range fetch address.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- MEM_BYTES, 256: instruction memory size in bytes. A fetch is legal only when pc <= MEM_BYTES-4.
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- mem_address  output  32  byte address to instruction memory; always equals the pc register.
- mem_instruction  input  32  word read combinationally from memory at mem_address, little-endian assembled.
- redirect_valid  input  1  taken branch/jump this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- id_ready  input  1  decode accepts if_* this cycle.
- if_valid  output  1  IF/ID register holds a valid instruction.
- if_instruction  output  32  registered instruction.
- if_pc  output  32  address of if_instruction.
- if_pc_plus4  output  32  if_pc + 4, mod 2^32.
- fault  output  1  sticky fetch fault.
- fault_pc  output  32  offending address.

## Operation
- The FSM has three states: BOOT, RUN and HALT. Reset enters BOOT.
- BOOT -> RUN on the first clock edge after reset deasserts. No fetch occurs in BOOT.
- RUN -> HALT on a fault. HALT is left only by reset.
- A load is permitted when the state is RUN, redirect_valid=0, and (if_valid=0 or id_ready=1).
- On a permitted load, with pc legal:
  - if_instruction <= mem_instruction, if_pc <= pc, if_pc_plus4 <= pc+4;
  - if_valid <= 1, pc <= pc+4.
- On a permitted load with pc > MEM_BYTES-4:
  - state <= HALT, fault <= 1, fault_pc <= pc, if_valid <= 0;
  - pc is held.
- Otherwise, in RUN with if_valid=1 and id_ready=0 (no redirect): pc and all if_* outputs hold.
- In RUN with if_valid=0 and no permitted load: nothing changes.
- Redirect has the highest priority in RUN:
  - if_valid <= 0, which flushes the held instruction whether or not id_ready is high;
  - pc <= redirect_target; no load happens in that cycle.
- A redirect whose target has target[1:0] != 0:
  - state <= HALT, fault <= 1, fault_pc <= redirect_target, if_valid <= 0;
  - pc is not updated.
- Redirect in BOOT or HALT is ignored.
- In HALT, if_valid=0, pc is frozen, and fault/fault_pc hold.
- PC arithmetic is 32-bit unsigned and wraps. The bounds check uses full 32-bit compare, so a wrapped pc faults.
- Handshake: a transfer occurs on an edge where if_valid=1 and id_ready=1. if_* must not change while if_valid=1 and id_ready=0, except when flushed by a redirect.

## Timing
- Reset values, applied asynchronously on reset assertion:
  - pc = RESET_PC, state = BOOT;
  - if_valid = 0, if_instruction = 0, if_pc = 0, if_pc_plus4 = 0;
  - fault = 0, fault_pc = 0.
  - mem_address = RESET_PC immediately.
- Reset asserted mid-operation discards any held instruction and the fault state at once.
- First fetch after reset: edge E1 moves BOOT->RUN. Edge E2 loads the word at RESET_PC, so if_valid=1 after E2.
- Steady state with id_ready=1: one instruction per cycle, and if_pc advances by 4 each edge.
- Redirect sampled at edge N: if_valid=0 after N. The target instruction is valid after N+1, a one-bubble penalty.
- Redirect together with id_ready=1 at the same edge: the current if_* transfers to decode, and the load is replaced by the redirect.
- Fault: fault rises at the edge that detects it and stays high until reset.

## Test plan
- Reset/boot:
  - Stimulus: memory word 0 = 00800513, word 1 = 00950593, id_ready=1, release reset.
  - Required: if_valid=0 after E1. After E2: if_instruction=00800513, if_pc=0, if_pc_plus4=4. After E3: if_instruction=00950593, if_pc=4.
- Backpressure:
  - Stimulus: drop id_ready for 3 cycles while if_pc=8.
  - Required: if_pc=8, instruction and mem_address=12 stable for all 3 cycles. On id_ready=1, if_pc=12 on the next edge.
- Redirect:
  - Stimulus: redirect_valid=1, target=0x00000010 at edge N, with id_ready=0.
  - Required: if_valid=0 after N. After N+1: if_pc=0x10 with the word at 0x10. No instruction is lost or duplicated.
- Misaligned redirect:
  - Stimulus: redirect to 0x00000006.
  - Required: fault=1, fault_pc=6, if_valid=0. Everything stays frozen for 10 cycles.
- Out of range:
  - Stimulus: MEM_BYTES=16, sequential fetch from 0.
  - Required: instructions at pc 0, 4, 8, 12 are delivered. Then fault=1 with fault_pc=16.
- Reset during HALT or backpressure:
  - Stimulus: assert reset asynchronously, between clock edges.
  - Required: fault=0, if_valid=0, mem_address=RESET_PC without waiting for a clock edge. Normal boot sequence follows.
